ins_memory_loader: RTL and testbench

- Instruction-side companion to the processor/data-memory top: holds the program store that drives the processor's instruction bus from its instruction address.
- Before execution, the program is streamed in over a byte-wide valid/ready load port and verified by checksum.
- Execution is gated by `cpu_run`, which is asserted only after a verified load.
- Sits directly upstream of the processor's instruction input.

---
 rtl/ins_memory_loader.sv | 118 +++++++++++
 tb/tb_ins_memory_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_memory_loader.sv
// Instruction store with a checksummed byte-stream loader. The processor is
// held idle (cpu_run=0, ins_bus=0) until a load has been verified.
module ins_memory_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ins_address,
  output logic [DATA_W-1:0] ins_bus,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_error,
  output logic              cpu_run
);

  // One extra bit so a full-depth load length is representable.
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              xfer_c;
  logic              last_c;
  logic [DATA_W-1:0] sum_nxt_c;
  logic [LEN_W-1:0]  start_len_c;

  // Handshake, running checksum and length decode.
  assign xfer_c      = ld_valid & ld_ready;
  assign sum_nxt_c   = sum + ld_data;
  assign last_c      = (count == len - LEN_W'(1));
  assign start_len_c = (ld_len == '0) ? LEN_W'(DEPTH) : {1'b0, ld_len};

  // Load sequencer; all status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len      <= '0;
      count    <= '0;
      sum      <= '0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      ld_error <= 1'b0;
      cpu_run  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (ld_start) begin
            state    <= S_LOAD;
            len      <= start_len_c;
            count    <= '0;
            sum      <= '0;
            ld_ready <= 1'b1;
            ld_done  <= 1'b0;
            ld_error <= 1'b0;
            cpu_run  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer_c) begin
            sum   <= sum_nxt_c;
            count <= count + LEN_W'(1);
            if (last_c) begin
              state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer_c) begin
            ld_ready <= 1'b0;
            if (sum_nxt_c == '0) begin
              state   <= S_RUN;
              ld_done <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state    <= S_ERROR;
              ld_error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          ld_ready <= 1'b0;
          ld_done  <= 1'b0;
          ld_error <= 1'b0;
          cpu_run  <= 1'b0;
        end
      endcase
    end
  end

  // Program store write port; active only while the processor is held.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && xfer_c) begin
      mem[count[ADDR_W-1:0]] <= ld_data;
    end
  end

  // Zero-latency instruction fetch, masked while not running.
  assign ins_bus = cpu_run ? mem[ins_address] : '0;

endmodule

// File: tb/tb_ins_memory_loader.sv
// Bench for ins_memory_loader: program bytes are recorded in a scoreboard as
// they are streamed, then read back through the instruction port.
module tb_ins_memory_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] ins_address;
  logic [7:0] ins_bus;
  logic       ld_start;
  logic [7:0] ld_len;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_ready;
  logic       ld_done;
  logic       ld_error;
  logic       cpu_run;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] prog[$];
  int         checks = 0;
  int         failures = 0;

  ins_memory_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_address(ins_address),
    .ins_bus    (ins_bus),
    .ld_start   (ld_start),
    .ld_len     (ld_len),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_error   (ld_error),
    .cpu_run    (cpu_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse ld_start for one cycle; inputs change 1 time unit after the edge.
  task automatic start_load(input logic [7:0] len_field);
    ld_start = 1'b1;
    ld_len   = len_field;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  // Offer one byte until accepted, then idle ld_valid for gap cycles.
  task automatic send_byte(input logic [7:0] b, input bit is_data,
                           input logic [7:0] addr, input int gap);
    int n = 0;
    ld_data  = b;
    ld_valid = 1'b1;
    while (ld_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout: ld_ready=%b required 1 after %0d cycles", ld_ready, n);
    end
    if (is_data) sb.push_back('{addr, b});
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_data  = 8'hEE;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Stream prog[] followed by the checksum byte.
  task automatic send_prog(input logic [7:0] csum, input int gap);
    foreach (prog[i]) send_byte(prog[i], 1'b1, 8'(i), gap);
    send_byte(csum, 1'b0, 8'h00, gap);
  endtask

  // Pop every scoreboard entry and compare it against the fetch port.
  task automatic drain_scoreboard(input string tag);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ins_address = e.addr;
      #1;
      checks++;
      if (ins_bus !== e.data) begin
        failures++;
        $display("FAIL %s_mem[%0h]: got %h required %h", tag, e.addr, ins_bus, e.data);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ld_ready, ld_done, ld_error, cpu_run} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_status: got %b required 0000", {ld_ready, ld_done, ld_error, cpu_run});
    end
    checks++;
    if (ins_bus !== 8'h00) begin
      failures++;
      $display("FAIL reset_ins_bus: got %h required 00", ins_bus);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    prog = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_load(8'd4);
    send_prog(8'h56, 0);
    checks++;
    if ({ld_done, cpu_run, ld_error} !== 3'b110) begin
      failures++;
      $display("FAIL basic_status: done/run/err got %b required 110", {ld_done, cpu_run, ld_error});
    end
    ins_address = 8'd2;
    #1;
    checks++;
    if (ins_bus !== 8'h33) begin
      failures++;
      $display("FAIL basic_addr2: got %h required 33", ins_bus);
    end
    drain_scoreboard("basic");
  endtask

  task automatic test_bad_checksum();
    prog = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_load(8'd4);
    send_prog(8'h57, 0);
    sb.delete();
    checks++;
    if ({ld_done, cpu_run, ld_error} !== 3'b001) begin
      failures++;
      $display("FAIL badsum_status: done/run/err got %b required 001", {ld_done, cpu_run, ld_error});
    end
    for (int a = 0; a < 4; a += 2) begin
      ins_address = 8'(a);
      #1;
      checks++;
      if (ins_bus !== 8'h00) begin
        failures++;
        $display("FAIL badsum_bus[%0d]: got %h required 00", a, ins_bus);
      end
    end
    start_load(8'd4);
    checks++;
    if (ld_error !== 1'b0) begin
      failures++;
      $display("FAIL badsum_err_clear: got %b required 0", ld_error);
    end
    send_prog(8'h56, 0);
    checks++;
    if ({ld_done, cpu_run, ld_error} !== 3'b110) begin
      failures++;
      $display("FAIL reload_status: done/run/err got %b required 110", {ld_done, cpu_run, ld_error});
    end
    drain_scoreboard("reload");
  endtask

  task automatic test_full_depth();
    logic [7:0] s = 8'h00;
    prog.delete();
    for (int i = 0; i < 256; i++) begin
      prog.push_back(8'(i));
      s = s + 8'(i);
    end
    checks++;
    if (s !== 8'h80) begin
      failures++;
      $display("FAIL full_model_sum: got %h required 80", s);
    end
    start_load(8'd0);
    send_prog(8'h80, 0);
    checks++;
    if ({ld_done, cpu_run, ld_error} !== 3'b110) begin
      failures++;
      $display("FAIL full_status: done/run/err got %b required 110", {ld_done, cpu_run, ld_error});
    end
    ins_address = 8'hFF;
    #1;
    checks++;
    if (ins_bus !== 8'hFF) begin
      failures++;
      $display("FAIL full_addr_ff: got %h required ff", ins_bus);
    end
    drain_scoreboard("full");
  endtask

  task automatic test_backpressure();
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (ld_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_ready: got %b required 0", ld_ready);
      end
    end
    prog = '{8'h01, 8'h02, 8'h03};
    start_load(8'd3);
    send_prog(8'hFA, 5);
    checks++;
    if ({ld_done, cpu_run, ld_error} !== 3'b110) begin
      failures++;
      $display("FAIL gap_status: done/run/err got %b required 110", {ld_done, cpu_run, ld_error});
    end
    drain_scoreboard("gap");
  endtask

  task automatic test_async_reset();
    logic [7:0] s;
    prog = '{8'h5A, 8'hC3, 8'h99, 8'h10};
    start_load(8'd4);
    send_byte(prog[0], 1'b1, 8'd0, 0);
    send_byte(prog[1], 1'b1, 8'd1, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ld_ready, ld_done, ld_error, cpu_run} !== 4'b0000) begin
      failures++;
      $display("FAIL async_status: got %b required 0000", {ld_ready, ld_done, ld_error, cpu_run});
    end
    checks++;
    if (ins_bus !== 8'h00) begin
      failures++;
      $display("FAIL async_ins_bus: got %h required 00", ins_bus);
    end
    sb.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    s = 8'h00;
    foreach (prog[i]) s = s + prog[i];
    start_load(8'd4);
    send_prog(8'h00 - s, 0);
    checks++;
    if ({ld_done, cpu_run, ld_error} !== 3'b110) begin
      failures++;
      $display("FAIL async_reload: done/run/err got %b required 110", {ld_done, cpu_run, ld_error});
    end
    drain_scoreboard("async");
  endtask

  task automatic test_back_to_back();
    start_load(8'd1);
    checks++;
    if (cpu_run !== 1'b0) begin
      failures++;
      $display("FAIL b2b_run_drop: got %b required 0", cpu_run);
    end
    ld_start = 1'b1;
    ld_len   = 8'd5;
    send_byte(8'hA5, 1'b1, 8'd0, 0);
    ld_start = 1'b0;
    checks++;
    if (cpu_run !== 1'b0 || ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_mid: run/ready got %b%b required 01", cpu_run, ld_ready);
    end
    send_byte(8'h5B, 1'b0, 8'd0, 0);
    checks++;
    if ({ld_done, cpu_run, ld_error} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_status: done/run/err got %b required 110", {ld_done, cpu_run, ld_error});
    end
    drain_scoreboard("b2b");
  endtask

  initial begin
    rst_n       = 1'b0;
    ins_address = 8'h00;
    ld_start    = 1'b0;
    ld_len      = 8'h00;
    ld_data     = 8'h00;
    ld_valid    = 1'b0;
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_full_depth();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
